// File: rtl/reg16_pkg.sv
// Shared types and sizing for the 16x8 register-file loader and its storage.
// Loader FSM states plus the data, address and statistics widths.
package reg16_pkg;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int SW    = WIDTH + AW;

    localparam logic [WIDTH-1:0] HI_THRESH = WIDTH'(128);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/reg_file16x8.sv
// 16x8 register file, one write port and one registered read port (1-cycle latency).
// Storage is not reset; a same-address read and write returns the old contents.
module reg_file16x8
    import reg16_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking update of both ports gives read-before-write on a collision.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/reg16_loader.sv
// Clears, then loads 16 samples into the register file while tracking sum, max and high count.
// Stats update one cycle after each accepted beat; in_ready is high only in LOAD, done is held.
module reg16_loader
    import reg16_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] max,
    output logic [SW-1:0]    sum,
    output logic [AW:0]      hi_cnt,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    wr_ptr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             accept;
    logic             last_beat;
    logic             clear_last;
    logic             restart;

    assign accept     = in_valid && in_ready;
    assign last_beat  = (count == (AW+1)'(DEPTH-1));
    assign clear_last = (wr_ptr == AW'(DEPTH-1));
    assign restart    = start && (state == IDLE || state == DONE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   if (clear_last) state_nxt = LOAD;
            LOAD:    if (accept && last_beat) state_nxt = DONE;
            DONE:    if (start) state_nxt = CLEAR;
            default: state_nxt = IDLE;
        endcase
    end

    // The write port is shared by the zero-fill sweep and the sample load.
    always_comb begin
        in_ready = (state == LOAD);
        busy     = (state == CLEAR) || (state == LOAD);
        done     = (state == DONE);
        wr_en    = (state == CLEAR) || ((state == LOAD) && in_valid);
        wr_data  = (state == LOAD) ? in_data : '0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            count  <= '0;
            max    <= '0;
            sum    <= '0;
            hi_cnt <= '0;
        end else if (restart) begin
            wr_ptr <= '0;
            count  <= '0;
            max    <= '0;
            sum    <= '0;
            hi_cnt <= '0;
        end else if (state == CLEAR) begin
            wr_ptr <= wr_ptr + AW'(1);
        end else if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + (AW+1)'(1);
            sum    <= sum + SW'(in_data);
            if (in_data > max) begin
                max <= in_data;
            end
            if (in_data >= HI_THRESH) begin
                hi_cnt <= hi_cnt + (AW+1)'(1);
            end
        end
    end

    reg_file16x8 u_reg_file (
        .Clk     (Clk),
        .Rst     (Rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: doc/reg16_loader.md
Name: reg16_loader

Overview:
Writer side of the 16x8 register-file interface. Accepts a stream of 8-bit samples over a valid/ready handshake and writes them sequentially into an internal 16-entry register file. While loading, it accumulates the sum, the maximum and a count of samples >= 128. It asserts done once all 16 entries are written; downstream scan FSMs then read the contents through a read port.

Parameters:
DEPTH, 16, number of entries; must be a power of 2.
WIDTH, 8, data width in bits.
AW, 4, address width = log2(DEPTH).
SW, 12, sum width = WIDTH + AW (16 x 255 = 4080 fits).

Ports:
Clk  in  1  clock; all logic on posedge.
Rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle request to begin a clear+load pass.
in_valid  in  1  input sample valid.
in_data  in  WIDTH  input sample.
in_ready  out  1  loader can accept a sample this cycle.
busy  out  1  high in CLEAR or LOAD.
done  out  1  all DEPTH entries loaded; level, held.
count  out  AW+1  number of samples accepted so far (0..16).
max  out  WIDTH  largest sample accepted this pass.
sum  out  SW  sum of samples accepted this pass.
hi_cnt  out  AW+1  number of accepted samples >= 128.
rd_en  in  1  read enable.
rd_addr  in  AW  read address.
rd_data  out  WIDTH  registered read data, valid 1 cycle after rd_en.

Behaviour:
- Reset (Rst=1 at posedge): state=IDLE; in_ready=0, busy=0, done=0, count=0, max=0, sum=0, hi_cnt=0, rd_data=0, wr_ptr=0. Register-file contents are not reset. Rst mid-pass abandons the pass immediately.
- States: IDLE, CLEAR, LOAD, DONE.
- IDLE: start=1 -> CLEAR, with wr_ptr=0, count=0, max=0, sum=0, hi_cnt=0, done=0.
- CLEAR: writes 0 to mem[wr_ptr] each cycle and increments wr_ptr; takes exactly DEPTH cycles. When wr_ptr wraps from 15 to 0 -> LOAD. in_ready=0 throughout.
- LOAD: in_ready=1. A beat is accepted when in_valid && in_ready at a posedge. On accept:
  - mem[wr_ptr] <= in_data; wr_ptr++; count++.
  - sum <= sum + in_data (zero-extended).
  - max <= (in_data > max) ? in_data : max.
  - hi_cnt++ if in_data[WIDTH-1].
  - If this is the 16th accept (count was 15) -> DONE, and in_ready drops in the next cycle. No 17th beat can be accepted.
- in_valid=0 in LOAD: hold, no update. Stall length is unbounded.
- DONE: done=1, busy=0, in_ready=0. Outputs are held. start=1 -> CLEAR, clearing done and stats as in IDLE.
- start in CLEAR or LOAD: ignored.
- busy = (state==CLEAR || state==LOAD).
- Read port: active in every state. If rd_en, rd_data <= mem[rd_addr] at the next posedge; otherwise rd_data holds.
- Read and write to the same address in the same cycle: read returns the OLD contents (read-before-write).
- All stats registers are registered; their values reflect accepts up to the previous edge.

Decomposition:
- Shared package reg16_pkg:
  - state enum (IDLE=0, CLEAR=1, LOAD=2, DONE=3);
  - DEPTH, WIDTH, AW and SW constants;
  - HI_THRESH=128.
- One sub-module, reg_file16x8: 1 write port, 1 registered read port, no reset on storage.
- The FSM and statistics logic live in reg16_loader.

Test Plan:
- Reset then start; in_valid held 1 with data 0..15 -> CLEAR lasts 16 cycles; 16 accepts in consecutive cycles; done=1. Final values: sum=120, max=15, hi_cnt=0, count=16. Reads of addr k return k.
- Load 200,10,255,128, then twelve 1s with random in_valid gaps -> sum=605, max=255, hi_cnt=3. in_ready=0 after the 16th accept; a 17th valid beat is not written.
- start pulsed during LOAD -> ignored; count continues.
- start in DONE -> done falls and stats zero. All 16 entries read 0 after CLEAR, before new data is written.
- Rst asserted after 5 accepts -> all outputs 0 next cycle. A new start plus 16 beats gives correct totals.
- rd_en to addr 3 in the same cycle a write to addr 3 is accepted -> rd_data = old value. A read in the next cycle returns the new value.
